// File: rtl/pdm_decimator.sv
// PDM-to-PCM receiver: 2nd-order CIC, decimation by 2**LOG2_DECIM, saturated and left-justified.
// Optional input synchronizer enabled by defining PDM_DECIMATOR_SYNC_EN.
module pdm_decimator #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             warm
);
  localparam int W  = 2*LOG2_DECIM + 1;
  localparam int YW = 2*LOG2_DECIM;
  localparam int SH = OUT_W - YW;

  // pcm_valid is a one-cycle strobe with no backpressure: the consumer must take
  // pcm_out on that cycle; pcm_out holds its value until the next strobe.

  typedef enum logic [1:0] {WARM0, WARM1, RUN} warm_state_e;

  logic                  pdm_bit;
  logic [W-1:0]          i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0]          d1_q, d1_d, d2_q, d2_d;
  logic [W-1:0]          c2_q, c2_d;
  logic [W-1:0]          c1, c2;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic                  emit_q, emit_d;
  warm_state_e           state_q, state_d;
  logic [OUT_W-1:0]      pcm_out_q, pcm_out_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic                  warm_q, warm_d;
  logic [YW-1:0]         y_sat;

`ifdef PDM_DECIMATOR_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d  = {sync_q[0], pdm_in};
  assign pdm_bit = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end
`else
  assign pdm_bit = pdm_in;
`endif

  always_comb begin
    i1_d        = i1_q;
    i2_d        = i2_q;
    cnt_d       = cnt_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    c2_d        = c2_q;
    state_d     = state_q;
    pcm_out_d   = pcm_out_q;
    warm_d      = warm_q;
    emit_d      = 1'b0;
    pcm_valid_d = 1'b0;
    y_sat       = '0;
    c1          = i2_q - d1_q;
    c2          = c1 - d2_q;
    tick_d      = ena && (cnt_q == '1);

    if (ena) begin
      i1_d  = i1_q + W'(pdm_bit);
      i2_d  = i2_q + i1_d;
      cnt_d = cnt_q + 1'b1;
    end

    // The first two comb results are built on a partly-filled delay line; drop them.
    if (tick_q) begin
      d1_d   = i2_q;
      d2_d   = c1;
      c2_d   = c2;
      emit_d = (state_q == RUN);
      case (state_q)
        WARM0:   state_d = WARM1;
        WARM1:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    // Top bit set means y == R**2, one step past the representable range.
    y_sat = c2_q[W-1] ? '1 : c2_q[YW-1:0];
    if (emit_q) begin
      pcm_out_d   = OUT_W'(y_sat) << SH;
      pcm_valid_d = 1'b1;
      warm_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q        <= '0;
      i2_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      c2_q        <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      emit_q      <= 1'b0;
      state_q     <= WARM0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      warm_q      <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      c2_q        <= c2_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      emit_q      <= emit_d;
      state_q     <= state_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      warm_q      <= warm_d;
    end
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;
  assign warm      = warm_q;
endmodule

// File: tb/tb_pdm_decimator.sv
// Random/directed bench for pdm_decimator; expected samples come from a direct
// triangular-kernel convolution of the consumed PDM bits.
module tb_pdm_decimator;
  localparam int L     = 6;
  localparam int OUT_W = 16;
  localparam int R     = 1 << L;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             pdm_in = 1'b0;
  logic [OUT_W-1:0] pcm_out;
  logic             pcm_valid;
  logic             warm;

  pdm_decimator #(.LOG2_DECIM(L), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pdm_in(pdm_in),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .warm(warm)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;

  // reference model state
  int hist[$];
  int nsamp = 0;
  int nwin  = 0;
  int s1 = 0, s2 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Order-2 CIC over one window == convolution with a triangle of length 2R-1.
  function automatic int cic_window();
    int sum = 0;
    int sz = hist.size();
    for (int k = 0; k < sz; k++) begin
      int h = (k < R) ? k + 1 : 2*R - 1 - k;
      sum += h * hist[sz-1-k];
    end
    return sum;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    nsamp = 0;
    nwin  = 0;
    s1 = 0;
    s2 = 0;
  endtask

  task automatic model_edge(input int e, input int b);
    int bit_used;
    int y;
`ifdef PDM_DECIMATOR_SYNC_EN
    bit_used = s2;
    s2 = s1;
    s1 = b;
`else
    bit_used = b;
`endif
    if (e != 0) begin
      hist.push_back(bit_used);
      if (hist.size() > 2*R - 1) void'(hist.pop_front());
      nsamp++;
      if (nsamp % R == 0) begin
        nwin++;
        if (nwin >= 3) begin
          y = cic_window();
          if (y > R*R - 1) y = R*R - 1;
          exp_q.push_back(OUT_W'(y * (1 << (OUT_W - 2*L))));
          exp_cyc_q.push_back(cyc + 2);
        end
      end
    end
  endtask

  // driver
  task automatic step(input int e, input int b);
    ena    = e[0];
    pdm_in = b[0];
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(e, b);
    #1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pcm_out", pcm_out, 0);
    check("rst_pcm_valid", pcm_valid, 0);
    check("rst_warm", warm, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      check("missed_strobe", 0, 1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (pcm_valid) begin
      if (exp_cyc_q.size() == 0 || exp_cyc_q[0] != cyc) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        check("pcm_out", pcm_out, exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        check("warm_on_strobe", warm, 1);
      end
    end
  end

  initial begin
    // reset block
    rst_n = 1'b0;
    repeat (3) step(0, 0);
    check("init_pcm_out", pcm_out, 0);
    check("init_pcm_valid", pcm_valid, 0);
    check("init_warm", warm, 0);
    rst_n = 1'b1;

    // all ones
    repeat (6*R) step(1, 1);
    // all zeros
    repeat (5*R) step(1, 0);
    // alternating 1,0
    for (int i = 0; i < 4*R; i++) step(1, (i % 2 == 0) ? 1 : 0);
    // random density
    for (int w = 0; w < 4; w++) begin
      int thr = $urandom_range(0, 100);
      for (int i = 0; i < R; i++) step(1, ($urandom_range(0, 99) < thr) ? 1 : 0);
    end
    // step 0->1 on a window boundary
    repeat (3*R) step(1, 0);
    repeat (3*R) step(1, 1);
    // ena toggling every other cycle, all ones
    for (int i = 0; i < 8*R; i++) step(i % 2, 1);
    // random ena and data
    for (int i = 0; i < 8*R; i++) step($urandom_range(0, 1), $urandom_range(0, 1));

    // align to a window boundary, run 30 samples, then reset
    while (nsamp % R != 0) step(1, $urandom_range(0, 1));
    repeat (30) step(1, 1);
    async_reset();
    repeat (150) step(1, 1);
    check("warm_after_rst", warm, 0);
    repeat (3*R - 150) step(1, 1);

    // long all-ones run wraps the 13-bit integrators
    repeat (130*R) step(1, 1);
    repeat (5*R) step(1, $urandom_range(0, 1));

    repeat (4) step(0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
